// File: rtl/sram_stream_reader_if.sv
// -----------------------------------------------------------------------------
// sram_stream_reader_if
//
// Output word stream of sram_stream_reader toward the operand feeders.
// Signal names keep the reader's port naming so waveforms read the same
// whether probed at the interface or inside the reader.
//
//   o_data   DATA_WIDTH  FIFO head word (reader -> consumer)
//   o_valid  1           head word present (reader -> consumer)
//   o_last   1           head word is the final word of the run
//   i_ready  1           consumer takes the head when o_valid & i_ready
//
// Modports:
//   master  the reader side (drives data/valid/last, samples ready)
//   slave   the consumer side
// -----------------------------------------------------------------------------
interface sram_stream_reader_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] o_data;
    logic                  o_valid;
    logic                  o_last;
    logic                  i_ready;

    modport master (
        output o_data,
        output o_valid,
        output o_last,
        input  i_ready
    );

    modport slave (
        input  o_data,
        input  o_valid,
        input  o_last,
        output i_ready
    );
endinterface

// File: rtl/sram_stream_reader.sv
// -----------------------------------------------------------------------------
// sram_stream_reader
//
// Read-side sequencer for one single-port SRAM bank. A start command in IDLE
// latches base address, word count and stride, then the block issues one read
// per cycle (as long as the output FIFO can absorb the result), captures the
// bank's registered read data one cycle later and streams it out through a
// small first-word-fall-through FIFO on a valid/ready handshake.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   i_start           start pulse, only looked at in IDLE
//   i_base_addr       first read address
//   i_len             word count 0..2^ADDR_WIDTH
//   i_stride          address increment (stride build only, see below)
//   o_busy            high in READ, DRAIN and DONE
//   o_done            one-cycle completion pulse
//   o_sram_rd_wr_en   bank port mode, constant 0 (read)
//   o_sram_addr       bank address
//   i_sram_rd_data    bank registered read data
//   stream            output word stream (sram_stream_reader_if.master)
//
// Build option:
//   SRAM_RD_STRIDE_EN  defined: i_stride is latched and used as the address
//                      increment. Undefined: the increment is fixed at 1 and
//                      i_stride is ignored (port kept so both builds share
//                      one interface).
// -----------------------------------------------------------------------------
module sram_stream_reader #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 10,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_start,
    input  logic [ADDR_WIDTH-1:0] i_base_addr,
    input  logic [ADDR_WIDTH:0]   i_len,
    input  logic [ADDR_WIDTH-1:0] i_stride,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_sram_rd_wr_en,
    output logic [ADDR_WIDTH-1:0] o_sram_addr,
    input  logic [DATA_WIDTH-1:0] i_sram_rd_data,
    sram_stream_reader_if.master  stream
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    state_t                state_q,         state_d;
    logic [ADDR_WIDTH-1:0] addr_q,          addr_d;       // next address to issue
    logic [ADDR_WIDTH-1:0] last_addr_q,     last_addr_d;  // address shown while idle
    logic [ADDR_WIDTH:0]   remaining_q,     remaining_d;  // reads still to issue
    logic                  inflight_q,      inflight_d;   // bank data valid this cycle
    logic                  inflight_last_q, inflight_last_d;
    logic [CNT_W-1:0]      count_q,         count_d;
    logic [PTR_W-1:0]      wr_ptr_q,        rd_ptr_q;
    logic [DATA_WIDTH:0]   fifo_mem_q [FIFO_DEPTH];       // {last, data}

`ifdef SRAM_RD_STRIDE_EN
    logic [ADDR_WIDTH-1:0] stride_q, stride_d;
    logic [ADDR_WIDTH-1:0] addr_incr;
    assign addr_incr = stride_q;
`else
    logic [ADDR_WIDTH-1:0] addr_incr;
    logic                  unused_stride;
    assign addr_incr     = ADDR_WIDTH'(1);
    // The stride port only exists to keep both builds pin-compatible.
    assign unused_stride = ^i_stride;
`endif

    // -------------------------------------------------------------------------
    // FIFO bookkeeping
    // -------------------------------------------------------------------------
    logic             push;
    logic             pop;
    logic             issue;
    logic             can_issue;
    logic [CNT_W:0]   occupancy;

    // Capture is unconditional on inflight: the issue rule already reserved
    // a slot for every outstanding read.
    assign push = inflight_q;
    assign pop  = (count_q != '0) && stream.i_ready;

    // Slots committed after this cycle: stored words plus the word arriving
    // from the bank, minus the word leaving now. Counting the pop lets a full
    // pipeline keep issuing every cycle while the consumer is ready.
    assign occupancy = {1'b0, count_q}
                     + {{CNT_W{1'b0}}, inflight_q}
                     - {{CNT_W{1'b0}}, pop};

    assign can_issue = (state_q == ST_READ)
                    && (remaining_q != '0)
                    && (occupancy < (CNT_W+1)'(FIFO_DEPTH));

    assign count_d = count_q + CNT_W'(push) - CNT_W'(pop);

    // -------------------------------------------------------------------------
    // Next-state / datapath control
    // -------------------------------------------------------------------------
    always_comb begin
        state_d         = state_q;
        addr_d          = addr_q;
        last_addr_d     = last_addr_q;
        remaining_d     = remaining_q;
        inflight_d      = 1'b0;
        inflight_last_d = 1'b0;
        issue           = 1'b0;
`ifdef SRAM_RD_STRIDE_EN
        stride_d        = stride_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (i_start) begin
                    addr_d      = i_base_addr;
                    remaining_d = i_len;
`ifdef SRAM_RD_STRIDE_EN
                    stride_d    = i_stride;
`endif
                    state_d     = (i_len != '0) ? ST_READ : ST_DONE;
                end
            end

            ST_READ: begin
                if (can_issue) begin
                    issue           = 1'b1;
                    last_addr_d     = addr_q;
                    addr_d          = addr_q + addr_incr;   // wraps modulo 2^ADDR_WIDTH
                    remaining_d     = remaining_q - (ADDR_WIDTH+1)'(1);
                    inflight_d      = 1'b1;
                    inflight_last_d = (remaining_q == (ADDR_WIDTH+1)'(1));
                    if (remaining_q == (ADDR_WIDTH+1)'(1)) begin
                        state_d = ST_DRAIN;
                    end
                end
            end

            ST_DRAIN: begin
                // Leave once the final word is handshaken in this very cycle,
                // so o_done follows the last handshake by exactly one cycle.
                if (!inflight_q && (count_d == '0)) begin
                    state_d = ST_DONE;
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Control registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= ST_IDLE;
            addr_q          <= '0;
            last_addr_q     <= '0;
            remaining_q     <= '0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
            count_q         <= '0;
            wr_ptr_q        <= '0;
            rd_ptr_q        <= '0;
        end else begin
            state_q         <= state_d;
            addr_q          <= addr_d;
            last_addr_q     <= last_addr_d;
            remaining_q     <= remaining_d;
            inflight_q      <= inflight_d;
            inflight_last_q <= inflight_last_d;
            count_q         <= count_d;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
        end
    end

`ifdef SRAM_RD_STRIDE_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stride_q <= '0;
        end else begin
            stride_q <= stride_d;
        end
    end
`endif

    // -------------------------------------------------------------------------
    // FIFO storage: one write port per entry, selected by the write pointer.
    // Contents need no reset; the head is gated by the count.
    // -------------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < FIFO_DEPTH; gi++) begin : g_fifo_entry
            always_ff @(posedge clk) begin
                if (push && (wr_ptr_q == PTR_W'(gi))) begin
                    fifo_mem_q[gi] <= {inflight_last_q, i_sram_rd_data};
                end
            end
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    logic [DATA_WIDTH:0] head_word;
    logic                fifo_valid;

    assign fifo_valid = (count_q != '0);
    assign head_word  = fifo_mem_q[rd_ptr_q];

    assign stream.o_valid = fifo_valid;
    assign stream.o_data  = fifo_valid ? head_word[DATA_WIDTH-1:0] : '0;
    assign stream.o_last  = fifo_valid ? head_word[DATA_WIDTH]     : 1'b0;

    // During an issue the bank sees the fresh address; otherwise it keeps the
    // previous one (a repeated read there is discarded since inflight is low).
    assign o_sram_addr     = issue ? addr_q : last_addr_q;
    assign o_sram_rd_wr_en = 1'b0;
    assign o_busy          = (state_q != ST_IDLE);
    assign o_done          = (state_q == ST_DONE);

endmodule
